// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared constants, error codes and FSM states for the UDP digit parser
package udp_rx_pkg;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_LOAD     = 8'h01;
  localparam logic [7:0] CMD_CLEAR    = 8'h02;
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_LEN      = 3'd1;
  localparam logic [2:0] ERR_SYNC     = 3'd2;
  localparam logic [2:0] ERR_CSUM     = 3'd3;
  localparam logic [2:0] ERR_HEX      = 3'd4;
  localparam logic [2:0] ERR_CMD      = 3'd5;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_CSUM, ST_DRAIN} state_t;
endpackage

// File: rtl/udp_rx_digit_parser_hex.sv
// ascii_hex_decode: maps an ASCII hex character to its nibble and flags non-hex bytes
module ascii_hex_decode (
  input  logic [7:0] in,
  output logic [3:0] nibble,
  output logic       is_hex
);
  logic is_dec, is_alpha;
  // Digits map directly; 'A'-'F' and 'a'-'f' share the same low nibble 1..6
  always_comb begin
    is_dec   = in >= 8'h30 && in <= 8'h39;
    is_alpha = (in >= 8'h41 && in <= 8'h46) || (in >= 8'h61 && in <= 8'h66);
    is_hex   = is_dec || is_alpha;
    nibble   = is_dec ? in[3:0] : is_alpha ? in[3:0] + 4'd9 : 4'd0;
  end
endmodule

// File: rtl/udp_rx_digit_parser.sv
// udp_rx_digit_parser: validates framed hex display commands from the UDP payload stream
module udp_rx_digit_parser
  import udp_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter int         NUM_DIGITS = 8,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                    udp_rx_clk,
  input  logic                    reset,
  input  logic                    app_rx_data_valid,
  input  logic [7:0]              app_rx_data,
  input  logic [15:0]             app_rx_data_length,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    digits_upd,
  output logic [15:0]             pkt_ok_cnt,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic [2:0]              last_err,
  output logic                    busy
);
  localparam logic [15:0] PKT_LEN   = 16'(NUM_DIGITS + 3);
  localparam logic [15:0] LAST_DATA = 16'(NUM_DIGITS + 1);
  state_t                  state;
  logic [15:0]             len, byte_idx;
  logic [7:0]              acc, cmd;
  logic [4*NUM_DIGITS-1:0] shreg;
  logic                    hex_bad;
  logic [2:0]              pend_err;
  logic [3:0]              nib;
  logic                    is_hex;
  logic [ERR_CNT_W-1:0]    err_inc;
  ascii_hex_decode u_dec (.in(app_rx_data), .nibble(nib), .is_hex(is_hex));
  assign err_inc = err_cnt + ERR_CNT_W'(~&err_cnt);
  assign busy    = state != ST_IDLE;
  // Frame parser: every valid byte advances the FSM; rejections and loads land on the consuming edge
  always_ff @(posedge udp_rx_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      byte_idx   <= '0;
      acc        <= '0;
      cmd        <= '0;
      shreg      <= '0;
      hex_bad    <= 1'b0;
      pend_err   <= ERR_NONE;
      digits     <= '0;
      digits_upd <= 1'b0;
      pkt_ok_cnt <= '0;
      err_cnt    <= '0;
      last_err   <= ERR_NONE;
    end else begin
      digits_upd <= 1'b0;
      if (app_rx_data_valid) begin
        case (state)
          ST_IDLE: begin
            len      <= app_rx_data_length;
            byte_idx <= 16'd1;
            acc      <= app_rx_data;
            hex_bad  <= 1'b0;
            if (app_rx_data_length < 16'd2) begin
              err_cnt  <= err_inc;
              last_err <= ERR_LEN;
            end else if (app_rx_data_length != PKT_LEN) begin
              state    <= ST_DRAIN;
              pend_err <= ERR_LEN;
            end else if (app_rx_data != SYNC_BYTE) begin
              state    <= ST_DRAIN;
              pend_err <= ERR_SYNC;
            end else begin
              state <= ST_CMD;
            end
          end
          ST_CMD: begin
            cmd      <= app_rx_data;
            acc      <= acc ^ app_rx_data;
            byte_idx <= byte_idx + 16'd1;
            state    <= ST_DATA;
          end
          ST_DATA: begin
            shreg    <= {shreg[4*NUM_DIGITS-5:0], nib};
            hex_bad  <= hex_bad | ~is_hex;
            acc      <= acc ^ app_rx_data;
            byte_idx <= byte_idx + 16'd1;
            if (byte_idx == LAST_DATA) state <= ST_CSUM;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (app_rx_data != acc) begin
              err_cnt  <= err_inc;
              last_err <= ERR_CSUM;
            end else if (hex_bad) begin
              err_cnt  <= err_inc;
              last_err <= ERR_HEX;
            end else if (cmd != CMD_LOAD && cmd != CMD_CLEAR) begin
              err_cnt  <= err_inc;
              last_err <= ERR_CMD;
            end else begin
              digits     <= cmd == CMD_LOAD ? shreg : '0;
              digits_upd <= 1'b1;
              pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
              last_err   <= ERR_NONE;
            end
          end
          ST_DRAIN: begin
            if (byte_idx == len - 16'd1) begin
              state    <= ST_IDLE;
              err_cnt  <= err_inc;
              last_err <= pend_err;
            end else begin
              byte_idx <= byte_idx + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_udp_rx_digit_parser.sv
// tb_udp_rx_digit_parser: randomized frames checked against a packet-level reference model
module tb_udp_rx_digit_parser;
  import udp_rx_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
  logic [7:0]  data = '0;
  logic [15:0] len_in = '0;
  logic [31:0] digits;
  logic        digits_upd, busy;
  logic [15:0] pkt_ok_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  last_err;
  int          errors = 0, checks = 0, upd_cnt = 0, m_upd = 0;
  logic [31:0] m_digits = '0;
  logic [15:0] m_ok = '0;
  logic [7:0]  m_err = '0;
  logic [2:0]  m_last = '0;
  logic [7:0]  fr[$];
  string       hs = "0123456789ABCDEFabcdef";
  string       bad_chars = "GgZz/:@` ";

  udp_rx_digit_parser dut (
    .udp_rx_clk(clk), .reset(rst_n), .app_rx_data_valid(vld), .app_rx_data(data),
    .app_rx_data_length(len_in), .digits(digits), .digits_upd(digits_upd),
    .pkt_ok_cnt(pkt_ok_cnt), .err_cnt(err_cnt), .last_err(last_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (digits_upd) upd_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " digits"}, 64'(digits), 64'(m_digits));
    check({tag, " upd_pulses"}, 64'(upd_cnt), 64'(m_upd));
    check({tag, " pkt_ok_cnt"}, 64'(pkt_ok_cnt), 64'(m_ok));
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(m_err));
    check({tag, " last_err"}, 64'(last_err), 64'(m_last));
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic put(input logic [7:0] b, input logic [15:0] l, input int gap);
    repeat (gap) begin
      @(negedge clk);
      vld = 1'b0;
    end
    @(negedge clk);
    vld = 1'b1;
    data = b;
    len_in = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    return -1;
  endfunction

  task automatic reject(input logic [2:0] code);
    m_err = m_err == 8'hFF ? 8'hFF : m_err + 8'd1;
    m_last = code;
  endtask

  task automatic model_pkt(input logic [7:0] q[$], input logic [15:0] l);
    logic [7:0] x;
    logic [31:0] val;
    bit bad;
    int h;
    if (l < 2) begin
      foreach (q[i]) reject(ERR_LEN);
      return;
    end
    if (l != 16'd11) begin
      reject(ERR_LEN);
      return;
    end
    if (q[0] != 8'hA5) begin
      reject(ERR_SYNC);
      return;
    end
    x = '0;
    for (int i = 0; i < 10; i++) x ^= q[i];
    bad = 0;
    val = '0;
    for (int i = 2; i < 10; i++) begin
      h = hexval(q[i]);
      if (h < 0) bad = 1;
      else val = val * 16 + 32'(h);
    end
    if (q[10] != x) reject(ERR_CSUM);
    else if (bad) reject(ERR_HEX);
    else if (q[1] != 8'h01 && q[1] != 8'h02) reject(ERR_CMD);
    else begin
      m_digits = q[1] == 8'h01 ? val : 32'd0;
      m_ok++;
      m_upd++;
      m_last = ERR_NONE;
    end
  endtask

  task automatic make_frame(input logic [7:0] cmd, input string s, input logic [7:0] flip);
    logic [7:0] x;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(cmd);
    for (int i = 0; i < s.len(); i++) fr.push_back(s[i]);
    x = '0;
    foreach (fr[i]) x ^= fr[i];
    fr.push_back(x ^ flip);
  endtask

  task automatic send(input logic [15:0] l, input int maxgap);
    foreach (fr[i]) put(fr[i], l, $urandom_range(maxgap));
    idle(3);
    model_pkt(fr, l);
  endtask

  function automatic string rand_hex();
    string s = "";
    for (int i = 0; i < 8; i++) s = {s, string'(hs[$urandom_range(hs.len() - 1)])};
    return s;
  endfunction

  initial begin
    string s;
    int kind;
    logic [15:0] l;
    idle(3);
    check_all("reset");
    rst_n = 1'b1;
    idle(2);

    make_frame(8'h01, "12345678", 8'h00);
    send(16'd11, 0);
    check_all("load_12345678");
    check("t1 digits const", 64'(digits), 64'h12345678);

    make_frame(8'h01, "12345678", 8'h01);
    send(16'd11, 0);
    check_all("bad_csum");
    check("t2 last_err const", 64'(last_err), 64'd3);
    make_frame(8'h01, "ABCDEF09", 8'h00);
    send(16'd11, 1);
    check_all("load_ABCDEF09");

    fr = '{8'hA5, 8'h01, 8'h31, 8'h32, 8'h33};
    for (int i = 0; i < 3; i++) put(fr[i], 16'd5, 0);
    idle(1);
    check("drain busy", 64'(busy), 64'd1);
    for (int i = 3; i < 5; i++) put(fr[i], 16'd5, 0);
    idle(3);
    model_pkt(fr, 16'd5);
    check_all("len5_drain");
    make_frame(8'h01, "0F1e2D3c", 8'h00);
    send(16'd11, 0);
    check_all("after_drain");

    make_frame(8'h01, "12G45678", 8'h00);
    send(16'd11, 0);
    check_all("hex_bad");
    make_frame(8'h02, "00000000", 8'h00);
    send(16'd11, 0);
    check_all("clear");
    make_frame(8'h07, "11111111", 8'h00);
    send(16'd11, 0);
    check_all("bad_cmd");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(5);
      s = rand_hex();
      l = 16'd11;
      case (kind)
        1: make_frame(8'h01, s, 8'($urandom_range(1, 255)));
        2: begin
          s[$urandom_range(7)] = bad_chars[$urandom_range(bad_chars.len() - 1)];
          make_frame(8'($urandom_range(1, 2)), s, 8'h00);
        end
        3: make_frame(8'($urandom_range(3, 255)), s, 8'h00);
        4: begin
          make_frame(8'h01, s, 8'h00);
          fr[0] = 8'h5A;
        end
        5: begin
          l = 16'($urandom_range(2, 20));
          if (l == 16'd11) l = 16'd12;
          fr.delete();
          for (int i = 0; i < int'(l); i++) fr.push_back(8'($urandom));
        end
        default: make_frame(8'($urandom_range(1, 2)), s, 8'h00);
      endcase
      send(l, 3);
      check_all($sformatf("rand%0d_k%0d", n, kind));
    end

    make_frame(8'h01, "DEADBEEF", 8'h00);
    for (int i = 0; i < 6; i++) put(fr[i], 16'd11, $urandom_range(3));
    @(negedge clk);
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    m_digits = '0;
    m_ok = '0;
    m_err = '0;
    m_last = '0;
    check_all("midpkt_reset");
    @(negedge clk);
    rst_n = 1'b1;
    make_frame(8'h01, "C0FFEE42", 8'h00);
    send(16'd11, 3);
    check_all("after_reset");
    check("t5 digits const", 64'(digits), 64'hC0FFEE42);

    fr.delete();
    for (int i = 0; i < 300; i++) fr.push_back(8'($urandom));
    send(16'd0, 0);
    check_all("len0_saturate");
    check("t6 err_cnt const", 64'(err_cnt), 64'hFF);

    @(negedge clk);
    force dut.pkt_ok_cnt = 16'hFFFE;
    #1;
    release dut.pkt_ok_cnt;
    m_ok = 16'hFFFE;
    make_frame(8'h01, "00000001", 8'h00);
    send(16'd11, 0);
    check_all("ok_ffff");
    make_frame(8'h01, "00000002", 8'h00);
    send(16'd11, 0);
    check_all("ok_wrap");
    check("t6 wrap const", 64'(pkt_ok_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
